dem_mis_sorter6: RTL and testbench

//  Mismatch-shaping sorter directly upstream of the 6-element digital selector.
//  - Takes the 6-bit selection vector the selector applied last sample (fed back).
//  - Keeps a usage integrator per unit element.
//  - Produces the priority-sorted element indices SQ5..SQ0 that drive the selector's SQ inputs.
//  - SQ0 is the least-used element (highest priority); SQ5 is the most-used.

---
 rtl/dem_mis_sorter6.sv | 167 ++++++++++++++++
 tb/tb_dem_mis_sorter6.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dem_mis_sorter6.sv
// Mismatch-shaping sorter for the 6-element DEM selector.
// Integrates element usage and emits element indices ordered least-used first.
module dem_mis_sorter6 #(
  parameter int W = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       IN_VLD,
  output logic       IN_RDY,
  input  logic [5:0] SV_FB,
  input  logic       MIS_SEL,
  output logic       OUT_VLD,
  output logic [2:0] SQ5,
  output logic [2:0] SQ4,
  output logic [2:0] SQ3,
  output logic [2:0] SQ2,
  output logic [2:0] SQ1,
  output logic [2:0] SQ0
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UPD,
    S_NORM,
    S_SORT,
    S_DONE
  } state_e;

  localparam logic [W-1:0] UMAX = '1;

  state_e state_q, state_d;
  logic [5:0] sv_q, sv_d;
  logic byp_q, byp_d;
  logic [2:0] p_q, p_d;
  logic [W-1:0] u_q [6];
  logic [W-1:0] u_d [6];
  logic [W-1:0] key_q [6];
  logic [W-1:0] key_d [6];
  logic [2:0] idx_q [6];
  logic [2:0] idx_d [6];
  logic [2:0] sq_q [6];
  logic [2:0] sq_d [6];

  logic [W-1:0] mn;
  logic [W-1:0] nk [6];
  logic [2:0] ni [6];

  always_comb begin
    mn = u_q[0];
    for (int i = 1; i < 6; i++) begin
      if (u_q[i] < mn) mn = u_q[i];
    end
  end

  // One odd-even transposition pass; pairs are disjoint so reads
  // come straight from the registered array.
  always_comb begin
    for (int j = 0; j < 6; j++) begin
      nk[j] = key_q[j];
      ni[j] = idx_q[j];
    end
    for (int j = 0; j < 5; j++) begin
      if ((j % 2) == int'(p_q[0])) begin
        if ((key_q[j] > key_q[j+1]) ||
            ((key_q[j] == key_q[j+1]) &&
             (idx_q[j] > idx_q[j+1]))) begin
          nk[j]   = key_q[j+1];
          nk[j+1] = key_q[j];
          ni[j]   = idx_q[j+1];
          ni[j+1] = idx_q[j];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sv_d    = sv_q;
    byp_d   = byp_q;
    p_d     = p_q;
    for (int i = 0; i < 6; i++) begin
      u_d[i]   = u_q[i];
      key_d[i] = key_q[i];
      idx_d[i] = idx_q[i];
      sq_d[i]  = sq_q[i];
    end
    unique case (state_q)
      S_IDLE: begin
        if (IN_VLD) begin
          sv_d    = SV_FB;
          byp_d   = MIS_SEL;
          state_d = S_UPD;
        end
      end
      S_UPD: begin
        if (!byp_q) begin
          for (int i = 0; i < 6; i++) begin
            if (sv_q[i] && (u_q[i] != UMAX)) begin
              u_d[i] = u_q[i] + 1'b1;
            end
          end
        end
        state_d = S_NORM;
      end
      S_NORM: begin
        for (int i = 0; i < 6; i++) begin
          u_d[i]   = u_q[i] - mn;
          key_d[i] = u_q[i] - mn;
          idx_d[i] = 3'(i);
        end
        p_d     = 3'd0;
        state_d = S_SORT;
      end
      S_SORT: begin
        for (int i = 0; i < 6; i++) begin
          key_d[i] = nk[i];
          idx_d[i] = ni[i];
        end
        p_d = p_q + 3'd1;
        if (p_q == 3'd5) begin
          for (int i = 0; i < 6; i++) begin
            sq_d[i] = byp_q ? 3'(i) : ni[i];
          end
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      sv_q    <= '0;
      byp_q   <= 1'b0;
      p_q     <= '0;
      for (int i = 0; i < 6; i++) begin
        u_q[i]   <= '0;
        key_q[i] <= '0;
        idx_q[i] <= 3'(i);
        sq_q[i]  <= 3'(i);
      end
    end else begin
      state_q <= state_d;
      sv_q    <= sv_d;
      byp_q   <= byp_d;
      p_q     <= p_d;
      for (int i = 0; i < 6; i++) begin
        u_q[i]   <= u_d[i];
        key_q[i] <= key_d[i];
        idx_q[i] <= idx_d[i];
        sq_q[i]  <= sq_d[i];
      end
    end
  end

  assign IN_RDY  = RST_N & (state_q == S_IDLE);
  assign OUT_VLD = (state_q == S_DONE);
  assign SQ0 = sq_q[0];
  assign SQ1 = sq_q[1];
  assign SQ2 = sq_q[2];
  assign SQ3 = sq_q[3];
  assign SQ4 = sq_q[4];
  assign SQ5 = sq_q[5];

endmodule

// File: tb/tb_dem_mis_sorter6.sv
// Bench for dem_mis_sorter6: per-cycle model compare plus directed literals.
module tb_dem_mis_sorter6;
  localparam int W = 4;
  localparam int MAXU = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_vld = 1'b0;
  logic mis_sel = 1'b0;
  logic [5:0] sv_fb = '0;
  logic in_rdy, out_vld;
  logic [2:0] sq0, sq1, sq2, sq3, sq4, sq5;

  int pass_cnt = 0;
  int total_cnt = 0;

  dem_mis_sorter6 #(.W(W)) dut (
    .CLK(clk), .RST_N(rst_n), .IN_VLD(in_vld), .IN_RDY(in_rdy),
    .SV_FB(sv_fb), .MIS_SEL(mis_sel), .OUT_VLD(out_vld),
    .SQ5(sq5), .SQ4(sq4), .SQ3(sq3), .SQ2(sq2), .SQ1(sq1), .SQ0(sq0)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int sq_of(int k);
    case (k)
      0: return int'(sq0);
      1: return int'(sq1);
      2: return int'(sq2);
      3: return int'(sq3);
      4: return int'(sq4);
      default: return int'(sq5);
    endcase
  endfunction

  // Model: usage counts, ranking by (count, index), latency counter
  int mu [6];
  int msq [6];
  int pend [6];
  int mcnt = 0;
  bit chk_en = 1'b0;

  task automatic model_sample(logic [5:0] sv, logic byp);
    int mn;
    bit used [6];
    if (!byp)
      for (int i = 0; i < 6; i++) begin
        mu[i] = mu[i] + int'(sv[i]);
        if (mu[i] > MAXU) mu[i] = MAXU;
      end
    mn = mu[0];
    for (int i = 1; i < 6; i++) if (mu[i] < mn) mn = mu[i];
    for (int i = 0; i < 6; i++) begin
      mu[i] -= mn;
      used[i] = 1'b0;
    end
    for (int k = 0; k < 6; k++) begin
      int best;
      best = -1;
      for (int i = 0; i < 6; i++)
        if (!used[i] && (best < 0 || mu[i] < mu[best])) best = i;
      used[best] = 1'b1;
      pend[k] = byp ? k : best;
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      mcnt = 0;
      for (int i = 0; i < 6; i++) begin
        mu[i] = 0;
        msq[i] = i;
      end
    end else if (mcnt == 0) begin
      if (in_vld) begin
        model_sample(sv_fb, mis_sel);
        mcnt = 1;
      end
    end else begin
      mcnt++;
      if (mcnt == 9) msq = pend;
      if (mcnt == 10) mcnt = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_vld", int'(out_vld), int'(mcnt == 9));
      chk("in_rdy", int'(in_rdy), int'(rst_n && mcnt == 0));
      for (int k = 0; k < 6; k++)
        chk($sformatf("sq%0d", k), sq_of(k), msq[k]);
    end
  end

  task automatic expect_sq(string name, int a0, int a1, int a2,
                           int a3, int a4, int a5);
    int e [6];
    e = '{a0, a1, a2, a3, a4, a5};
    for (int k = 0; k < 6; k++)
      chk($sformatf("%s_sq%0d", name, k), sq_of(k), e[k]);
  endtask

  // Starts and ends just after a negedge with the DUT idle
  task automatic send(string name, logic [5:0] sv, logic byp);
    int n;
    sv_fb = sv;
    mis_sel = byp;
    in_vld = 1'b1;
    @(posedge clk);
    #1 in_vld = 1'b0;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (out_vld) break;
    end
    chk({name, "_latency"}, n, 9);
    @(negedge clk);
    chk({name, "_rdy_again"}, int'(in_rdy), 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_rdy_low", int'(in_rdy), 0);
    chk("rst_vld_low", int'(out_vld), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rdy_high", int'(in_rdy), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses, first_p, last_p;
    @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    expect_sq("reset", 0, 1, 2, 3, 4, 5);
    do_reset();

    send("t2", 6'b000111, 1'b0);
    expect_sq("t2", 3, 4, 5, 0, 1, 2);
    send("t6a", 6'b100000, 1'b1);
    expect_sq("t6a", 0, 1, 2, 3, 4, 5);
    send("t6b", 6'b000000, 1'b0);
    expect_sq("t6b", 3, 4, 5, 0, 1, 2);
    send("t3", 6'b111000, 1'b0);
    expect_sq("t3", 0, 1, 2, 3, 4, 5);

    // IN_VLD held high: accepts only every 10 clocks
    pulses = 0;
    first_p = -1;
    last_p = -1;
    sv_fb = 6'b000010;
    mis_sel = 1'b0;
    in_vld = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 25) in_vld = 1'b0;
      if (out_vld) begin
        pulses++;
        if (first_p < 0) first_p = i;
        last_p = i;
      end
    end
    chk("t4_pulses", pulses, 3);
    chk("t4_first", first_p, 8);
    chk("t4_last", last_p, 28);
    expect_sq("t4", 0, 2, 3, 4, 5, 1);

    // Saturation: u0 climbs to MAXU and must stay there
    do_reset();
    for (int r = 0; r < MAXU + 2; r++) begin
      send("t5", 6'b000001, 1'b0);
      expect_sq($sformatf("t5_%0d", r), 1, 2, 3, 4, 5, 0);
    end

    // Reset mid-sort kills the pending result and clears integrators
    sv_fb = 6'b000100;
    in_vld = 1'b1;
    @(posedge clk);
    #1 in_vld = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_vld) pulses++;
    end
    chk("rstmid_no_vld", pulses, 0);
    expect_sq("rstmid", 0, 1, 2, 3, 4, 5);
    send("rstmid_u0", 6'b000000, 1'b0);
    expect_sq("rstmid_u0", 0, 1, 2, 3, 4, 5);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
